sync_fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the successor to our basic single-clock FIFO. It uses all `DEPTH` entries through wrap-bit pointers and exposes occupancy plus programmable almost-full/almost-empty flags. It offers a first-word-fall-through or registered-output read mode, accepts push on full when a pop lands in the same cycle, and provides synchronous flush and sticky overflow/underflow error flags. It sits between producer/consumer blocks on a single clock domain wherever buffering needs back-pressure margin.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/fifo_ptr.sv | 43 ++++
 rtl/sync_fifo_flex.sv | 154 +++++++++++++++
 tb/tb_sync_fifo_flex.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared helpers and constants for the sync_fifo_flex block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    // Pointer / count width: index bits plus one wrap bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Reset value replicated across the registered read-data bus.
    localparam logic DOUT_RST_BIT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
//  Module      : fifo_ptr
//  Description : Wrap-bit FIFO pointer with increment enable, flush and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Natural binary wrap at 2**W gives the extra lap bit for free.
    always_comb begin
        ptr_d = ptr_q;
        if (flush) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flex.sv
// ============================================================================
//  Module      : sync_fifo_flex
//  Description : Single-clock FIFO with FWFT/registered read, occupancy,
//                almost flags, flush and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BITS     = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int OUT_REG  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [BITS-1:0]           Din,
    input  logic                      pop,
    output logic [BITS-1:0]           Dout,
    output logic                      dval,
    output logic                      pndng,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = cnt_w(DEPTH);
    localparam logic [PW-1:0] c_af_level = PW'(AF_LEVEL);
    localparam logic [PW-1:0] c_ae_level = PW'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_chk_af
        $error("sync_fifo_flex: AF_LEVEL out of range 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_chk_ae
        $error("sync_fifo_flex: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty_w;
    logic            full_w;
    logic            pop_ok;
    logic            push_ok;
    logic            wr_en;
    logic            rd_en;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [BITS-1:0] mem_q [DEPTH];

    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[PW-1] != rd_ptr[PW-1]);

    // Push on full rides on a same-cycle pop; pop on empty never bypasses.
    assign pop_ok  = pop & ~empty_w;
    assign push_ok = push & (~full_w | pop_ok);
    assign wr_en   = push_ok & ~flush;
    assign rd_en   = pop_ok & ~flush;

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr[AW-1:0]] <= Din;
        end
    end

    // A rejection in the clearing cycle wins over clr_err.
    always_comb begin
        ovf_d = clr_err ? 1'b0 : ovf_q;
        unf_d = clr_err ? 1'b0 : unf_q;
        if (!flush && push && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (!flush && pop && !pop_ok) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [BITS-1:0] dout_q;
        logic            dval_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= {BITS{DOUT_RST_BIT}};
                dval_q <= 1'b0;
            end else if (flush) begin
                dval_q <= 1'b0;
            end else if (pop_ok) begin
                dout_q <= mem_q[rd_ptr[AW-1:0]];
                dval_q <= 1'b1;
            end else begin
                dval_q <= 1'b0;
            end
        end

        assign Dout = dout_q;
        assign dval = dval_q;
    end else begin : g_fwft
        assign Dout = mem_q[rd_ptr[AW-1:0]];
        assign dval = ~empty_w;
    end

    assign count        = wr_ptr - rd_ptr;
    assign empty        = empty_w;
    assign pndng        = ~empty_w;
    assign full         = full_w;
    assign almost_full  = (count >= c_af_level);
    assign almost_empty = (count <= c_ae_level);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
// ============================================================================
//  Module      : tb_sync_fifo_flex
//  Description : Scoreboard bench driving FWFT and registered-read FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_flex;

    localparam int DEPTH = 4;
    localparam int BITS  = 8;

    logic            clk;
    logic            rst, flush, push, pop, clr_err;
    logic [BITS-1:0] Din;

    logic [BITS-1:0] dout0, dout1;
    logic            dval0, dval1, pndng0, pndng1, empty0, empty1;
    logic            full0, full1, af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [2:0]      cnt0, cnt1;

    sync_fifo_flex #(.DEPTH(DEPTH), .BITS(BITS), .AF_LEVEL(3), .AE_LEVEL(1), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .Din(Din), .pop(pop),
        .Dout(dout0), .dval(dval0), .pndng(pndng0), .empty(empty0), .full(full0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    sync_fifo_flex #(.DEPTH(DEPTH), .BITS(BITS), .AF_LEVEL(3), .AE_LEVEL(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .Din(Din), .pop(pop),
        .Dout(dout1), .dval(dval1), .pndng(pndng1), .empty(empty1), .full(full1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents as a queue, plus scoreboard queues per DUT.
    logic [BITS-1:0] mdl[$];
    logic [BITS-1:0] exp0[$];
    logic [BITS-1:0] exp1[$];
    bit              m_ovf, m_unf, m_dval1;
    logic [BITS-1:0] m_hold1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_status();
        int c;
        c = mdl.size();
        chk("count0", int'(cnt0), c);
        chk("count1", int'(cnt1), c);
        chk("empty0", int'(empty0), int'(c == 0));
        chk("empty1", int'(empty1), int'(c == 0));
        chk("pndng0", int'(pndng0), int'(c != 0));
        chk("dval0", int'(dval0), int'(c != 0));
        chk("full0", int'(full0), int'(c == DEPTH));
        chk("full1", int'(full1), int'(c == DEPTH));
        chk("afull0", int'(af0), int'(c >= 3));
        chk("aempty0", int'(ae0), int'(c <= 1));
        chk("afull1", int'(af1), int'(c >= 3));
        chk("aempty1", int'(ae1), int'(c <= 1));
        chk("ovf0", int'(ovf0), int'(m_ovf));
        chk("unf0", int'(unf0), int'(m_unf));
        chk("ovf1", int'(ovf1), int'(m_ovf));
        chk("unf1", int'(unf1), int'(m_unf));
        chk("dval1", int'(dval1), int'(m_dval1));
        if (!m_dval1) chk("dout1_hold", int'(dout1), int'(m_hold1));
    endtask

    task automatic cyc(input bit r, input bit f, input bit pu, input logic [BITS-1:0] d,
                       input bit po, input bit c);
        bit pok, wok;
        @(negedge clk);
        check_status();
        rst = r; flush = f; push = pu; Din = d; pop = po; clr_err = c;
        if (r) begin
            mdl.delete(); exp0.delete();
            m_ovf = 0; m_unf = 0; m_dval1 = 0; m_hold1 = '0;
        end else begin
            pok = po && (mdl.size() > 0);
            wok = pu && ((mdl.size() < DEPTH) || pok);
            if (c) begin
                m_ovf = 0; m_unf = 0;
            end
            if (f) begin
                mdl.delete(); exp0.delete();
                m_dval1 = 0;
            end else begin
                if (pu && !wok) m_ovf = 1;
                if (po && !pok) m_unf = 1;
                m_dval1 = pok;
                if (pok) begin
                    m_hold1 = mdl.pop_front();
                    exp1.push_back(m_hold1);
                end
                if (wok) begin
                    mdl.push_back(d);
                    exp0.push_back(d);
                end
            end
        end
    endtask

    // Monitor: consumes scoreboard entries whenever a DUT presents read data.
    initial begin
        logic [BITS-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush && pop && pndng0) begin
                if (exp0.size() == 0) chk("fwft_unexpected", int'(dout0), -1);
                else begin
                    e = exp0.pop_front();
                    chk("fwft_data", int'(dout0), int'(e));
                end
            end
            if (dval1) begin
                if (exp1.size() == 0) chk("reg_unexpected", int'(dout1), -1);
                else begin
                    e = exp1.pop_front();
                    chk("reg_data", int'(dout1), int'(e));
                end
            end
        end
    end

    initial begin
        rst = 1; flush = 0; push = 0; pop = 0; clr_err = 0; Din = '0;
        m_ovf = 0; m_unf = 0; m_dval1 = 0; m_hold1 = '0;
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0);
        // Fill, then one rejected push
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 8'(i * 8'h11), 0, 0);
        // Drain, then one rejected pop
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 1);
        // Push+pop on full and on empty
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 8'(i), 0, 0);
        cyc(0, 0, 1, 8'h55, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1, 0);
        cyc(0, 0, 1, 8'h66, 1, 0);
        cyc(0, 0, 0, 8'h00, 1, 1);
        // Registered read latency and hold
        cyc(0, 0, 1, 8'hA5, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 0);
        // Flush at count 3 with overflow set, then clear errors
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'hB0 + i), 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 0);
        cyc(0, 1, 1, 8'hEE, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 1);
        // Mid-stream reset
        cyc(0, 0, 1, 8'hC1, 0, 0);
        cyc(0, 0, 1, 8'hC2, 1, 0);
        cyc(1, 0, 1, 8'hC3, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        // Wrap at occupancy 2
        cyc(0, 0, 1, 8'h70, 0, 0);
        cyc(0, 0, 1, 8'h71, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'(8'h72 + i), 1, 0);
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 8'h00, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        chk("reg_scoreboard_drained", exp1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
